// File: rtl/router_pkg.sv
// Shared router types and constants for the switch allocator slice.
package router_pkg;

    localparam int NUM_OF_PORTS      = 5;
    localparam int NUM_OF_PORTS_BITS = $clog2(NUM_OF_PORTS) + 1;

    // Route / crossbar select. An MSB of 1 marks an invalid route or an idle output.
    typedef logic [NUM_OF_PORTS_BITS-1:0] ROUTE_t;

    localparam ROUTE_t ROUTE_INVALID = {1'b1, {(NUM_OF_PORTS_BITS-1){1'b0}}};

    typedef enum logic {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } ALLOC_STATE_t;

    // A route names a real output only if its MSB is clear and it is in range.
    function automatic logic route_ok(ROUTE_t r);
        return !r[NUM_OF_PORTS_BITS-1] && (r < ROUTE_t'(NUM_OF_PORTS));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr+1.
module rr_arbiter #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    int idx;

    // Scan N positions starting just after the last winner, wrapping modulo N.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(idx);
                gnt[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Per-output switch allocator. Each output locks to one input from head to tail
// and hands over round-robin without a bubble when the owner's tail goes through.
//
// state  | meaning
// FREE   | output idle, arbitrates any candidate each cycle
// LOCKED | output owned by owner_q until owner forwards a valid tail
module switch_allocator
    import router_pkg::*;
(
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [NUM_OF_PORTS-1:0]                          i_req,
    input  logic [NUM_OF_PORTS-1:0][NUM_OF_PORTS_BITS-1:0]   i_route,
    input  logic [NUM_OF_PORTS-1:0]                          i_flit_valid,
    input  logic [NUM_OF_PORTS-1:0]                          i_tail,
    output logic [NUM_OF_PORTS-1:0]                          o_ack,
    output logic [NUM_OF_PORTS-1:0][NUM_OF_PORTS_BITS-1:0]   o_xbar_sel,
    output logic [NUM_OF_PORTS-1:0]                          o_out_busy
);

    localparam int N     = NUM_OF_PORTS;
    localparam int PTR_W = $clog2(N);

    ALLOC_STATE_t       state_q [N];
    ALLOC_STATE_t       state_d [N];
    ROUTE_t             owner_q [N];
    ROUTE_t             owner_d [N];
    logic [PTR_W-1:0]   ptr_q   [N];
    logic [PTR_W-1:0]   ptr_d   [N];

    logic [N-1:0]       ack_q, ack_d;
    logic [N-1:0]       busy_q, busy_d;
    ROUTE_t [N-1:0]     xbar_sel_q, xbar_sel_d;

    logic [N-1:0]       cand [N];
    logic [N-1:0]       arb_gnt [N];
    logic [PTR_W-1:0]   arb_idx [N];
    logic [N-1:0]       arb_valid;
    logic [N-1:0]       release_tail;

    logic [N-1:0]       own_hit [N];
    logic [N-1:0]       sel_hit [N];

    // Candidates per output: requesting, routed here, and not already owning an output.
    // The ~ack term is what keeps a releasing owner out of its own handover.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            cand[j] = '0;
            for (int i = 0; i < N; i++) begin
                cand[j][i] = i_req[i] & route_ok(i_route[i]) &
                             (i_route[i] == ROUTE_t'(j)) & ~ack_q[i];
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_arb
        rr_arbiter #(
            .N  (N),
            .IW (PTR_W)
        ) u_rr_arbiter (
            .req       (cand[j]),
            .ptr       (ptr_q[j]),
            .gnt       (arb_gnt[j]),
            .gnt_idx   (arb_idx[j]),
            .gnt_valid (arb_valid[j])
        );
    end

    // Next state per output, then outputs derived from next state so they are registered.
    always_comb begin
        release_tail = '0;
        ack_d        = '0;
        busy_d       = '0;
        xbar_sel_d   = '0;
        for (int j = 0; j < N; j++) begin
            state_d[j] = state_q[j];
            owner_d[j] = owner_q[j];
            ptr_d[j]   = ptr_q[j];
            for (int i = 0; i < N; i++) begin
                if (state_q[j] == LOCKED && owner_q[j] == ROUTE_t'(i)) begin
                    release_tail[j] = i_flit_valid[i] & i_tail[i];
                end
            end
            if (state_q[j] == FREE || release_tail[j]) begin
                if (arb_valid[j]) begin
                    state_d[j] = LOCKED;
                    owner_d[j] = ROUTE_t'(arb_idx[j]);
                    ptr_d[j]   = arb_idx[j];
                end else begin
                    state_d[j] = FREE;
                    owner_d[j] = ROUTE_INVALID;
                end
            end
        end
        for (int j = 0; j < N; j++) begin
            busy_d[j]     = (state_d[j] == LOCKED);
            xbar_sel_d[j] = busy_d[j] ? owner_d[j] : ROUTE_INVALID;
            for (int i = 0; i < N; i++) begin
                if (busy_d[j] && owner_d[j] == ROUTE_t'(i)) begin
                    ack_d[i] = 1'b1;
                end
            end
        end
    end

    // State, pointer and output registers; pointers restart so input 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < N; j++) begin
                state_q[j] <= FREE;
                owner_q[j] <= ROUTE_INVALID;
                ptr_q[j]   <= PTR_W'(N - 1);
            end
            ack_q      <= '0;
            busy_q     <= '0;
            xbar_sel_q <= {N{ROUTE_INVALID}};
        end else begin
            for (int j = 0; j < N; j++) begin
                state_q[j] <= state_d[j];
                owner_q[j] <= owner_d[j];
                ptr_q[j]   <= ptr_d[j];
            end
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            xbar_sel_q <= xbar_sel_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_out_busy = busy_q;
    assign o_xbar_sel = xbar_sel_q;

    // Ownership matrices (input x output) used by the invariants below.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            own_hit[i] = '0;
            sel_hit[i] = '0;
            for (int j = 0; j < N; j++) begin
                own_hit[i][j] = (state_q[j] == LOCKED) && (owner_q[j] == ROUTE_t'(i));
                sel_hit[i][j] = (xbar_sel_q[j] == ROUTE_t'(i));
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_chk_out
        a_owner_valid : assert property (@(posedge clk) disable iff (reset)
            (state_q[j] == LOCKED) |-> !owner_q[j][NUM_OF_PORTS_BITS-1]);
        a_gnt_onehot : assert property (@(posedge clk) disable iff (reset)
            arb_valid[j] == $onehot(arb_gnt[j]));
    end

    for (genvar i = 0; i < N; i++) begin : g_chk_in
        a_single_owner : assert property (@(posedge clk) disable iff (reset)
            $countones(own_hit[i]) <= 1);
        a_sel_onehot : assert property (@(posedge clk) disable iff (reset)
            $countones(sel_hit[i]) <= 1);
    end

endmodule

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;
    import router_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [4:0]       i_req, i_flit_valid, i_tail;
    logic [4:0][3:0]  i_route;
    logic [4:0]       o_ack, o_out_busy;
    logic [4:0][3:0]  o_xbar_sel;

    switch_allocator dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_route      (i_route),
        .i_flit_valid (i_flit_valid),
        .i_tail       (i_tail),
        .o_ack        (o_ack),
        .o_xbar_sel   (o_xbar_sel),
        .o_out_busy   (o_out_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: owner per output (-1 = free) and last winner per output.
    int m_owner [5] = '{-1, -1, -1, -1, -1};
    int m_ptr   [5] = '{4, 4, 4, 4, 4};
    bit m_on = 1'b0;

    always @(posedge clk) begin
        int nxt_o [5];
        int nxt_p [5];
        bit acked [5];
        int w, c, o;
        bit open;
        for (int i = 0; i < 5; i++) acked[i] = 1'b0;
        for (int j = 0; j < 5; j++) if (m_owner[j] >= 0) acked[m_owner[j]] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            nxt_o[j] = m_owner[j];
            nxt_p[j] = m_ptr[j];
            o = m_owner[j];
            open = (o < 0) || (i_flit_valid[o] && i_tail[o]);
            if (open) begin
                w = -1;
                for (int k = 1; k <= 5; k++) begin
                    c = (m_ptr[j] + k) % 5;
                    if (w < 0 && i_req[c] && !acked[c] && int'(i_route[c]) == j) w = c;
                end
                nxt_o[j] = w;
                if (w >= 0) nxt_p[j] = w;
            end
            if (reset) begin
                nxt_o[j] = -1;
                nxt_p[j] = 4;
            end
        end
        if (reset) m_on <= 1'b1;
        for (int j = 0; j < 5; j++) begin
            m_owner[j] <= nxt_o[j];
            m_ptr[j]   <= nxt_p[j];
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        int ea, eb;
        if (m_on) begin
            ea = 0;
            eb = 0;
            for (int j = 0; j < 5; j++) begin
                if (m_owner[j] >= 0) begin
                    ea = ea | (1 << m_owner[j]);
                    eb = eb | (1 << j);
                end
                check("model_xbar_sel", int'(o_xbar_sel[j]), (m_owner[j] >= 0) ? m_owner[j] : 8);
            end
            check("model_ack", int'(o_ack), ea);
            check("model_busy", int'(o_out_busy), eb);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        i_req        = '0;
        i_flit_valid = '0;
        i_tail       = '0;
        for (int i = 0; i < 5; i++) i_route[i] = 4'd8;
    endtask

    task automatic send_packet(int src, int n, int out, int exp_next);
        for (int f = 0; f < n; f++) begin
            i_flit_valid[src] = 1'b1;
            i_tail[src]       = (f == n - 1);
            if (f == n - 1) i_req[src] = 1'b0;
            cyc();
            if (f < n - 1) check("hold_owner", int'(o_xbar_sel[out]), src);
            else           check("handover", int'(o_xbar_sel[out]), exp_next);
        end
        i_flit_valid[src] = 1'b0;
        i_tail[src]       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) cyc();
        reset = 1'b0;
        check("reset_ack", int'(o_ack), 0);
        check("reset_busy", int'(o_out_busy), 0);
        for (int j = 0; j < 5; j++) check("reset_xbar_sel", int'(o_xbar_sel[j]), 8);

        // Single grant
        i_req[2] = 1'b1; i_route[2] = 4'd1;
        cyc();
        check("single_ack", int'(o_ack), 5'b00100);
        check("single_sel", int'(o_xbar_sel[1]), 2);
        check("single_busy", int'(o_out_busy), 5'b00010);
        check("model_pin_owner1", m_owner[1], 2);
        send_packet(2, 1, 1, 8);
        check("single_release", int'(o_out_busy), 0);
        idle();

        // Contention: 0,3,4 on output 2, three flits each
        i_req = 5'b11001;
        i_route[0] = 4'd2; i_route[3] = 4'd2; i_route[4] = 4'd2;
        cyc();
        check("cont_first", int'(o_xbar_sel[2]), 0);
        check("cont_ack", int'(o_ack), 5'b00001);
        i_flit_valid[3] = 1'b1; i_tail[3] = 1'b1;
        cyc();
        check("nonowner_tail", int'(o_xbar_sel[2]), 0);
        i_flit_valid[3] = 1'b0; i_tail[3] = 1'b0;
        send_packet(0, 3, 2, 3);
        check("model_pin_ptr2", m_ptr[2], 3);
        send_packet(3, 3, 2, 4);
        send_packet(4, 3, 2, 8);
        check("cont_free", int'(o_out_busy), 0);
        idle();

        // Fairness wrap: last winner 4, inputs 0 and 4 re-request
        i_req = 5'b10001;
        i_route[0] = 4'd2; i_route[4] = 4'd2;
        cyc();
        check("wrap_first", int'(o_xbar_sel[2]), 0);
        send_packet(0, 1, 2, 4);
        send_packet(4, 1, 2, 8);
        idle();

        // Parallel disjoint grants
        i_req = 5'b00011;
        i_route[0] = 4'd1; i_route[1] = 4'd0;
        cyc();
        check("par_ack", int'(o_ack), 5'b00011);
        check("par_sel1", int'(o_xbar_sel[1]), 0);
        check("par_sel0", int'(o_xbar_sel[0]), 1);
        i_tail = 5'b00011;
        cyc();
        check("tail_no_valid", int'(o_out_busy), 5'b00011);
        i_flit_valid = 5'b00011; i_req = '0;
        cyc();
        check("par_release", int'(o_out_busy), 0);
        idle();

        // Invalid routes never granted
        i_req[3] = 1'b1;
        for (int c = 0; c < 25; c++) begin
            i_route[3] = (c < 20) ? 4'd8 : 4'd6;
            cyc();
            check("inv_ack3", int'(o_ack[3]), 0);
            check("inv_busy", int'(o_out_busy), 0);
        end
        idle();

        // Reset mid-packet
        i_req[0] = 1'b1; i_route[0] = 4'd2;
        cyc();
        check("rst_pre", int'(o_xbar_sel[2]), 0);
        reset = 1'b1;
        i_req[3] = 1'b1; i_route[3] = 4'd2;
        cyc();
        check("rst_ack", int'(o_ack), 0);
        check("rst_sel2", int'(o_xbar_sel[2]), 8);
        reset = 1'b0;
        cyc();
        check("rst_rearb", int'(o_xbar_sel[2]), 0);
        check("rst_rearb_ack", int'(o_ack), 5'b00001);
        send_packet(0, 2, 2, 3);
        send_packet(3, 1, 2, 8);
        idle();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
